// File: rtl/bram_pattern_sequencer.sv
// BRAM sweep checker: writes a pattern to addresses 0..DEPTH-1, reads them back and compares against the same pattern.
// A sweep takes 2*DEPTH+2 cycles from start to done; it has no backpressure and can only be stopped by abort or rst.
module bram_pattern_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 11,
  parameter int DEPTH      = 2048,
  parameter int ERR_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [1:0]            pattern_sel,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic                  bram_en,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_WIDTH-1:0]  error_count,
  output logic [ADDR_WIDTH-1:0] first_fail_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int CW = (ADDR_WIDTH < DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ERR_WIDTH-1:0]  ERR_MAX   = '1;

  // Pattern value for one word; a_lo is the address truncated or zero-extended to DATA_WIDTH.
  function automatic logic [DATA_WIDTH-1:0] pattern(
    input logic [1:0]            sel,
    input logic [DATA_WIDTH-1:0] sd,
    input logic [DATA_WIDTH-1:0] a_lo
  );
    logic [DATA_WIDTH-1:0] p;
    case (sel)
      2'd0:    p = sd;
      2'd1:    p = sd ^ a_lo;
      2'd2:    p = a_lo[0] ? ~sd : sd;
      default: p = sd + a_lo;
    endcase
    return p;
  endfunction

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] seed_q, seed_d;
  logic [1:0]            sel_q, sel_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic                  en_d, we_d, busy_d, done_d, pass_d;
  logic [DATA_WIDTH-1:0] din_d;
  logic [ERR_WIDTH-1:0]  err_d;
  logic [ADDR_WIDTH-1:0] ffa_d;
  logic                  launch, abort_hit, mismatch;
  logic [DATA_WIDTH-1:0] addr_d_lo, addr_q_lo;

  // Read-compare pipeline: the expected value and its address follow each read by one cycle.
  logic                  rd_pend_q, rd_pend_d;
  logic [DATA_WIDTH-1:0] rd_exp_q, rd_exp_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;

  assign addr_d_lo = DATA_WIDTH'(addr_d[CW-1:0]);
  assign addr_q_lo = DATA_WIDTH'(bram_addr[CW-1:0]);

  always_comb begin
    state_d   = state_q;
    addr_d    = bram_addr;
    seed_d    = seed_q;
    sel_d     = sel_q;
    launch    = 1'b0;
    abort_hit = abort && (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WRITE;
          addr_d  = '0;
          seed_d  = seed;
          sel_d   = pattern_sel;
          launch  = 1'b1;
        end
      end
      S_WRITE: begin
        if (bram_addr == LAST_ADDR) begin
          state_d = S_READ;
          addr_d  = '0;
        end else begin
          addr_d = bram_addr + ADDR_WIDTH'(1);
        end
      end
      S_READ: begin
        if (bram_addr == LAST_ADDR) begin
          state_d = S_DRAIN;
          addr_d  = '0;
        end else begin
          addr_d = bram_addr + ADDR_WIDTH'(1);
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort_hit) begin
      state_d = S_IDLE;
      addr_d  = '0;
    end

    en_d   = (state_d == S_WRITE) || (state_d == S_READ);
    we_d   = (state_d == S_WRITE);
    din_d  = we_d ? pattern(sel_d, seed_d, addr_d_lo) : '0;
    busy_d = (state_d == S_WRITE) || (state_d == S_READ) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);

    rd_pend_d = (state_q == S_READ) && !abort_hit;
    rd_exp_d  = pattern(sel_q, seed_q, addr_q_lo);
    rd_addr_d = bram_addr;

    // Abort wins over a compare landing on the same edge.
    mismatch = rd_pend_q && (bram_dout != rd_exp_q) && !abort_hit;

    err_d = error_count;
    ffa_d = first_fail_addr;
    if (launch) begin
      err_d = '0;
      ffa_d = '0;
    end else if (mismatch) begin
      if (error_count == '0) ffa_d = rd_addr_q;
      if (error_count != ERR_MAX) err_d = error_count + ERR_WIDTH'(1);
    end

    pass_d = pass;
    if (launch || abort_hit) begin
      pass_d = 1'b0;
    end else if (state_q == S_DRAIN) begin
      pass_d = (err_d == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      seed_q          <= '0;
      sel_q           <= '0;
      bram_en         <= 1'b0;
      bram_we         <= 1'b0;
      bram_addr       <= '0;
      bram_din        <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      error_count     <= '0;
      first_fail_addr <= '0;
      rd_pend_q       <= 1'b0;
      rd_exp_q        <= '0;
      rd_addr_q       <= '0;
    end else begin
      state_q         <= state_d;
      seed_q          <= seed_d;
      sel_q           <= sel_d;
      bram_en         <= en_d;
      bram_we         <= we_d;
      bram_addr       <= addr_d;
      bram_din        <= din_d;
      busy            <= busy_d;
      done            <= done_d;
      pass            <= pass_d;
      error_count     <= err_d;
      first_fail_addr <= ffa_d;
      rd_pend_q       <= rd_pend_d;
      rd_exp_q        <= rd_exp_d;
      rd_addr_q       <= rd_addr_d;
    end
  end

endmodule

// File: tb/tb_bram_pattern_sequencer.sv
// Directed bench for bram_pattern_sequencer with two behavioural BRAMs and read-data corruption hooks.
module tb_bram_pattern_sequencer;
  localparam int DW = 8;
  localparam int AW = 11;
  localparam int D  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          abort;
  logic          start, start2;
  logic [1:0]    sel, sel2;
  logic [DW-1:0] seed, seed2;

  logic          en, we, busy, done, pass;
  logic [AW-1:0] addr, ffa;
  logic [DW-1:0] din, dout;
  logic [15:0]   err;

  logic          en2, we2, busy2, done2, pass2;
  logic [AW-1:0] addr2, ffa2;
  logic [DW-1:0] din2, dout2;
  logic [1:0]    err2;

  int compared = 0;
  int mismatched = 0;

  logic [DW-1:0] mem  [0:D-1];
  logic [DW-1:0] mem2 [0:D-1];
  logic [DW-1:0] raw, raw2;
  logic [AW-1:0] rd_a;
  logic          corrupt_59;
  logic          invert2;

  always @(posedge clk) begin
    if (en) begin
      if (we) mem[addr[3:0]] <= din;
      else begin
        raw  <= mem[addr[3:0]];
        rd_a <= addr;
      end
    end
    if (en2) begin
      if (we2) mem2[addr2[3:0]] <= din2;
      else raw2 <= mem2[addr2[3:0]];
    end
  end

  assign dout  = (corrupt_59 && (rd_a == 11'd5 || rd_a == 11'd9)) ? 8'h00 : raw;
  assign dout2 = invert2 ? ~raw2 : raw2;

  bram_pattern_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(D), .ERR_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .pattern_sel(sel), .seed(seed),
    .bram_en(en), .bram_we(we), .bram_addr(addr), .bram_din(din), .bram_dout(dout),
    .busy(busy), .done(done), .pass(pass), .error_count(err), .first_fail_addr(ffa)
  );

  bram_pattern_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(D), .ERR_WIDTH(2)) u_sat (
    .clk(clk), .rst(rst), .start(start2), .abort(abort), .pattern_sel(sel2), .seed(seed2),
    .bram_en(en2), .bram_we(we2), .bram_addr(addr2), .bram_din(din2), .bram_dout(dout2),
    .busy(busy2), .done(done2), .pass(pass2), .error_count(err2), .first_fail_addr(ffa2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 1 of the new sweep.
  task automatic start_sweep(input logic [1:0] s, input logic [DW-1:0] sd);
    sel   = s;
    seed  = sd;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    compared++;
    if ({en, we, addr, din, busy, done, pass, err, ffa} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: got en=%b we=%b addr=%h din=%h busy=%b done=%b pass=%b err=%0d ffa=%h, want all 0",
               en, we, addr, din, busy, done, pass, err, ffa);
    end
    compared++;
    if ({en2, we2, busy2, done2, pass2, err2} !== '0) begin
      mismatched++;
      $display("FAIL reset_sat_outputs: got nonzero, want all 0");
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_const();
    int done_cyc = 0;
    int done_cnt = 0;
    start_sweep(2'd0, 8'hAA);
    for (int n = 1; n <= 40; n++) begin
      if (n == 1) begin
        compared++;
        if ({en, we, addr} !== {1'b1, 1'b1, 11'd0}) begin
          mismatched++;
          $display("FAIL const_first_write: got en=%b we=%b addr=%h, want 1 1 000", en, we, addr);
        end
      end
      if (n <= D) begin
        compared++;
        if (din !== 8'hAA || addr !== AW'(n - 1)) begin
          mismatched++;
          $display("FAIL const_write_c%0d: got addr=%h din=%h, want %h AA", n, addr, din, n - 1);
        end
      end
      if (n == 17) begin
        compared++;
        if ({en, we, addr, din} !== {1'b1, 1'b0, 11'd0, 8'h00}) begin
          mismatched++;
          $display("FAIL const_first_read: got en=%b we=%b addr=%h din=%h, want 1 0 000 00", en, we, addr, din);
        end
      end
      if (n == 33) begin
        compared++;
        if (en !== 1'b0 || busy !== 1'b1) begin
          mismatched++;
          $display("FAIL const_drain: got en=%b busy=%b, want 0 1", en, busy);
        end
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = n;
      end
      tick();
    end
    compared++;
    if (done_cyc != 34 || done_cnt != 1) begin
      mismatched++;
      $display("FAIL const_done_cycle: got cycle %0d count %0d, want cycle 34 count 1", done_cyc, done_cnt);
    end
    compared++;
    if (pass !== 1'b1 || err !== 16'd0 || ffa !== 11'd0) begin
      mismatched++;
      $display("FAIL const_result: got pass=%b err=%0d ffa=%h, want 1 0 000", pass, err, ffa);
    end
  endtask

  task automatic test_xor();
    start_sweep(2'd1, 8'h0F);
    for (int n = 1; n <= 36; n++) begin
      compared++;
      if (busy !== ((n >= 1 && n <= 33) ? 1'b1 : 1'b0)) begin
        mismatched++;
        $display("FAIL xor_busy_c%0d: got %b, want %b", n, busy, (n <= 33));
      end
      tick();
    end
    compared++;
    if (mem[3] !== 8'h0C) begin
      mismatched++;
      $display("FAIL xor_word3: got %h, want 0C", mem[3]);
    end
    compared++;
    if (pass !== 1'b1 || err !== 16'd0) begin
      mismatched++;
      $display("FAIL xor_result: got pass=%b err=%0d, want 1 0", pass, err);
    end
  endtask

  task automatic test_checker();
    int done_cyc = 0;
    corrupt_59 = 1'b1;
    start_sweep(2'd2, 8'h55);
    for (int n = 1; n <= 36; n++) begin
      if (n == 1 || n == 6) begin
        compared++;
        if (din !== ((n == 1) ? 8'h55 : 8'hAA)) begin
          mismatched++;
          $display("FAIL checker_din_c%0d: got %h, want %h", n, din, (n == 1) ? 8'h55 : 8'hAA);
        end
      end
      if (done === 1'b1 && done_cyc == 0) done_cyc = n;
      tick();
    end
    corrupt_59 = 1'b0;
    compared++;
    if (done_cyc != 34) begin
      mismatched++;
      $display("FAIL checker_done_cycle: got %0d, want 34", done_cyc);
    end
    compared++;
    if (err !== 16'd2 || ffa !== 11'h005 || pass !== 1'b0) begin
      mismatched++;
      $display("FAIL checker_result: got err=%0d ffa=%h pass=%b, want 2 005 0", err, ffa, pass);
    end
  endtask

  task automatic test_saturate();
    int done_cyc = 0;
    invert2 = 1'b1;
    sel2    = 2'd3;
    seed2   = 8'h10;
    start2  = 1'b1;
    tick();
    start2  = 1'b0;
    for (int n = 1; n <= 36; n++) begin
      if (n == 4) begin
        compared++;
        if (din2 !== 8'h13) begin
          mismatched++;
          $display("FAIL sat_din_c4: got %h, want 13", din2);
        end
      end
      if (done2 === 1'b1 && done_cyc == 0) done_cyc = n;
      tick();
    end
    invert2 = 1'b0;
    compared++;
    if (done_cyc != 34) begin
      mismatched++;
      $display("FAIL sat_done_cycle: got %0d, want 34", done_cyc);
    end
    compared++;
    if (err2 !== 2'd3 || pass2 !== 1'b0 || ffa2 !== 11'd0) begin
      mismatched++;
      $display("FAIL sat_result: got err=%0d pass=%b ffa=%h, want 3 0 000", err2, pass2, ffa2);
    end
  endtask

  task automatic test_abort();
    int done_seen = 0;
    int done_cyc = 0;
    start_sweep(2'd0, 8'h3C);
    for (int n = 1; n < 20; n++) tick();
    compared++;
    if (busy !== 1'b1 || we !== 1'b0 || en !== 1'b1) begin
      mismatched++;
      $display("FAIL abort_c20_state: got busy=%b en=%b we=%b, want 1 1 0", busy, en, we);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    compared++;
    if (en !== 1'b0 || we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin
      mismatched++;
      $display("FAIL abort_c21: got en=%b we=%b busy=%b done=%b pass=%b, want all 0", en, we, busy, done, pass);
    end
    for (int n = 0; n < 20; n++) begin
      if (done === 1'b1 || en === 1'b1) done_seen++;
      tick();
    end
    compared++;
    if (done_seen != 0) begin
      mismatched++;
      $display("FAIL abort_quiet: got %0d active cycles, want 0", done_seen);
    end
    start_sweep(2'd3, 8'hF0);
    for (int n = 1; n <= 36; n++) begin
      if (done === 1'b1 && done_cyc == 0) done_cyc = n;
      tick();
    end
    compared++;
    if (done_cyc != 34 || pass !== 1'b1 || mem[2] !== 8'hF2) begin
      mismatched++;
      $display("FAIL abort_restart: got done@%0d pass=%b mem2=%h, want 34 1 F2", done_cyc, pass, mem[2]);
    end
  endtask

  task automatic test_start_ignored_and_rst();
    int done_cyc = 0;
    start_sweep(2'd1, 8'h00);
    for (int n = 1; n < 10; n++) tick();
    start = 1'b1;
    seed  = 8'hFF;
    sel   = 2'd2;
    tick();
    start = 1'b0;
    compared++;
    if (din !== 8'h0A || addr !== 11'd10) begin
      mismatched++;
      $display("FAIL ignore_c11: got addr=%h din=%h, want 00A 0A", addr, din);
    end
    for (int n = 11; n <= 36; n++) begin
      if (done === 1'b1 && done_cyc == 0) done_cyc = n;
      tick();
    end
    compared++;
    if (done_cyc != 34 || pass !== 1'b1) begin
      mismatched++;
      $display("FAIL ignore_done: got done@%0d pass=%b, want 34 1", done_cyc, pass);
    end
    start_sweep(2'd0, 8'h11);
    for (int n = 1; n < 25; n++) tick();
    compared++;
    if (busy !== 1'b1 || en !== 1'b1) begin
      mismatched++;
      $display("FAIL rst_c25_pre: got busy=%b en=%b, want 1 1", busy, en);
    end
    #2;
    rst = 1'b1;
    #1;
    compared++;
    if ({en, we, addr, din, busy, done, pass, err, ffa} !== '0) begin
      mismatched++;
      $display("FAIL rst_midsweep: got en=%b we=%b addr=%h din=%h busy=%b err=%0d, want all 0",
               en, we, addr, din, busy, err);
    end
    rst = 1'b0;
    tick();
    tick();
    compared++;
    if (busy !== 1'b0 || en !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_stays_idle: got busy=%b en=%b, want 0 0", busy, en);
    end
  endtask

  initial begin
    rst        = 1'b1;
    abort      = 1'b0;
    start      = 1'b0;
    start2     = 1'b0;
    sel        = 2'd0;
    sel2       = 2'd0;
    seed       = '0;
    seed2      = '0;
    corrupt_59 = 1'b0;
    invert2    = 1'b0;
    test_reset();
    test_const();
    test_xor();
    test_checker();
    test_saturate();
    test_abort();
    test_start_ignored_and_rst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
